// File: rtl/event_unpack_gearbox.sv
// -----------------------------------------------------------------------------
// event_unpack_gearbox
//
// Packs a 64-bit SURF payload word stream into 512-bit AXI4-Stream beats.
//   EXPAND mode (mode 0): packed SAMPLE_BITS samples, optionally SURF
//     nibble-remapped per word, are widened to OUT_SAMPLE_BITS (zero-filled).
//   PASS mode (mode 1): eight raw 64-bit words are stacked per beat.
// Beats go through an internal first-word-fall-through FIFO. A frame whose last
// word lands mid-beat is zero-padded, closed with tlast and flagged.
//
// Optional build macro: EVENT_GEARBOX_STATS_EN adds beat_count_o and
// frame_count_o (beats / tlast beats actually written into the FIFO).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode_i              0=EXPAND, 1=PASS, latched on the first word of a frame
//   payload_i           64-bit input word
//   payload_valid_i     input word valid (no input backpressure)
//   payload_last_i      last word of frame, qualified by payload_valid_i
//   space_avail_o       free FIFO entries >= CHUNK_BEATS (registered)
//   m_axis_*            AXI4-Stream master (tdata 512, tkeep all ones)
//   err_partial_o       one-cycle pulse when a frame ends mid-beat
//   ovf_o               sticky, a beat was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module event_unpack_gearbox #(
    parameter int SAMPLE_BITS      = 12,
    parameter int OUT_SAMPLE_BITS  = 16,
    parameter int SAMPLES_PER_BEAT = 32,
    parameter int REMAP            = 1,
    parameter int FIFO_DEPTH       = 64,
    parameter int CHUNK_BEATS      = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode_i,
    input  logic [63:0]  payload_i,
    input  logic         payload_valid_i,
    input  logic         payload_last_i,
    output logic         space_avail_o,
    output logic [511:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [63:0]  m_axis_tkeep,
    output logic         err_partial_o,
    output logic         ovf_o
`ifdef EVENT_GEARBOX_STATS_EN
    ,
    output logic [31:0]  beat_count_o,
    output logic [31:0]  frame_count_o
`endif
);

    localparam int PACK_BITS  = SAMPLES_PER_BEAT * SAMPLE_BITS;
    localparam int WORDS_EXP  = PACK_BITS / 64;
    localparam int WORDS_PASS = 8;
    localparam int ACC_W      = (PACK_BITS > 512) ? PACK_BITS : 512;
    localparam int W_MAX      = (WORDS_EXP > WORDS_PASS) ? WORDS_EXP : WORDS_PASS;
    localparam int CNT_W      = $clog2(W_MAX);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam bit DO_REMAP   = (REMAP == 1) && (SAMPLE_BITS == 12);

    localparam logic [CNT_W-1:0] LAST_IDX_EXP  = CNT_W'(WORDS_EXP - 1);
    localparam logic [CNT_W-1:0] LAST_IDX_PASS = CNT_W'(WORDS_PASS - 1);
    localparam logic [PTR_W:0]   DEPTH_C       = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]      CHUNK_C       = 32'(CHUNK_BEATS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    // SURF nibble remap of one packed word into linear sample order.
    function automatic logic [63:0] surf_remap(input logic [63:0] d);
        logic [63:0] r;
        r          = 64'd0;
        r[0 +: 12]  = {d[48 +: 4], d[56 +: 8]};
        r[12 +: 12] = {d[40 +: 8], d[52 +: 4]};
        r[24 +: 12] = {d[24 +: 4], d[32 +: 8]};
        r[36 +: 12] = {d[16 +: 8], d[28 +: 4]};
        r[48 +: 12] = {d[0 +: 4],  d[8 +: 8]};
        r[60 +: 4]  = d[4 +: 4];
        return r;
    endfunction

    // Widen each packed sample of the accumulator to its output slot.
    function automatic logic [511:0] expand_beat(input logic [ACC_W-1:0] acc);
        logic [511:0] o;
        o = 512'd0;
        for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
            o[OUT_SAMPLE_BITS*i +: OUT_SAMPLE_BITS] =
                OUT_SAMPLE_BITS'(acc[SAMPLE_BITS*i +: SAMPLE_BITS]);
        end
        return o;
    endfunction

    // Gearbox state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               stage_vld_q, stage_vld_d;
    logic [511:0]       stage_data_q, stage_data_d;
    logic               stage_last_q, stage_last_d;
    logic               err_q, err_d;

    logic               cur_mode_s;
    logic [63:0]        word_s;
    logic [CNT_W-1:0]   last_idx_s;
    logic               at_end_s;

    // FIFO state
    logic [511:0]       mem_q [FIFO_DEPTH];
    logic               last_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               tvalid_q;
    logic               space_q;
    logic               ovf_q;
    logic               pop_s, full_s, push_s, drop_s;
    logic [31:0]        free_s;

    // Word packing: the frame's first word selects the mode, later words use the latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        acc_d        = acc_q;
        stage_vld_d  = 1'b0;
        stage_data_d = stage_data_q;
        stage_last_d = stage_last_q;
        err_d        = 1'b0;

        cur_mode_s = (state_q == ST_IDLE) ? mode_i : mode_q;
        last_idx_s = cur_mode_s ? LAST_IDX_PASS : LAST_IDX_EXP;
        at_end_s   = (cnt_q == last_idx_s);
        if (!cur_mode_s && DO_REMAP) begin
            word_s = surf_remap(payload_i);
        end else begin
            word_s = payload_i;
        end

        if (payload_valid_i) begin
            mode_d = cur_mode_s;
            acc_d[{cnt_q, 6'd0} +: 64] = word_s;
            if (at_end_s || payload_last_i) begin
                // Slots above cnt_q are still zero because acc is cleared on every close.
                stage_vld_d  = 1'b1;
                stage_last_d = payload_last_i;
                stage_data_d = cur_mode_s ? acc_d[511:0] : expand_beat(acc_d);
                err_d        = payload_last_i && !at_end_s;
                acc_d        = '0;
                cnt_d        = '0;
                state_d      = payload_last_i ? ST_IDLE : ST_FILL;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_FILL;
            end
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // FIFO control: a push while full is dropped unless the same cycle pops.
    always_comb begin
        pop_s  = tvalid_q && m_axis_tready;
        full_s = (count_q == DEPTH_C);
        push_s = stage_vld_q && (!full_s || pop_s);
        drop_s = stage_vld_q && full_s && !pop_s;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        free_s = 32'(DEPTH_C - count_d);
    end

    // Gearbox and FIFO control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            acc_q        <= '0;
            stage_vld_q  <= 1'b0;
            stage_data_q <= 512'd0;
            stage_last_q <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tvalid_q     <= 1'b0;
            space_q      <= (CHUNK_BEATS <= FIFO_DEPTH);
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            stage_vld_q  <= stage_vld_d;
            stage_data_q <= stage_data_d;
            stage_last_q <= stage_last_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tvalid_q     <= (count_d != '0);
            space_q      <= (free_s >= CHUNK_C);
            ovf_q        <= ovf_q || drop_s;
        end
    end

    // Beat storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q]      <= stage_data_q;
            last_mem_q[wr_ptr_q] <= stage_last_q;
        end
    end

    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign m_axis_tlast  = last_mem_q[rd_ptr_q];
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tkeep  = {64{1'b1}};
    assign space_avail_o = space_q;
    assign err_partial_o = err_q;
    assign ovf_o         = ovf_q;

`ifdef EVENT_GEARBOX_STATS_EN
    logic [31:0] beat_cnt_q;
    logic [31:0] frame_cnt_q;

    // Counts only beats that actually entered the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= 32'd0;
            frame_cnt_q <= 32'd0;
        end else begin
            if (push_s) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (push_s && stage_last_q) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
        end
    end

    assign beat_count_o  = beat_cnt_q;
    assign frame_count_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_event_unpack_gearbox.sv
module tb_event_unpack_gearbox;

    localparam int SB    = 12;
    localparam int OSB   = 16;
    localparam int SPB   = 32;
    localparam int WEXP  = SPB * SB / 64;
    localparam int DEPTH = 64;
    localparam int CHUNK = 48;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode_i;
    logic [63:0]  payload_i;
    logic         payload_valid_i;
    logic         payload_last_i;
    logic         space_avail_o;
    logic [511:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [63:0]  m_axis_tkeep;
    logic         err_partial_o;
    logic         ovf_o;
`ifdef EVENT_GEARBOX_STATS_EN
    logic [31:0]  beat_count_o;
    logic [31:0]  frame_count_o;
`endif

    always #5 clk = ~clk;

    event_unpack_gearbox dut (
        .clk             (clk),
        .rst             (rst),
        .mode_i          (mode_i),
        .payload_i       (payload_i),
        .payload_valid_i (payload_valid_i),
        .payload_last_i  (payload_last_i),
        .space_avail_o   (space_avail_o),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tkeep    (m_axis_tkeep),
        .err_partial_o   (err_partial_o),
        .ovf_o           (ovf_o)
`ifdef EVENT_GEARBOX_STATS_EN
        ,
        .beat_count_o    (beat_count_o),
        .frame_count_o   (frame_count_o)
`endif
    );

    typedef struct {
        logic [511:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        bit mode;
        int nwords;
        int exp_beats;
        int exp_err;
    } vec_t;

    beat_t       exp_q[$];
    logic [63:0] fw[$];
    int          checks = 0;
    int          failures = 0;
    int          beats_seen = 0;
    int          err_seen = 0;
    bit          exp_ovf = 1'b0;
    bit          rand_ready = 1'b0;

    // Spec-level SURF remap: packed word order -> linear sample bits.
    function automatic logic [63:0] remap(input logic [63:0] d);
        logic [63:0] r;
        r = 64'd0;
        r[0 +: 12]  = {d[48 +: 4], d[56 +: 8]};
        r[12 +: 12] = {d[40 +: 8], d[52 +: 4]};
        r[24 +: 12] = {d[24 +: 4], d[32 +: 8]};
        r[36 +: 12] = {d[16 +: 8], d[28 +: 4]};
        r[48 +: 12] = {d[0 +: 4],  d[8 +: 8]};
        r[60 +: 4]  = d[4 +: 4];
        return r;
    endfunction

    // Inverse of remap, used to build input words from desired samples.
    function automatic logic [63:0] unremap(input logic [63:0] r);
        logic [63:0] d;
        d = 64'd0;
        d[56 +: 8] = r[0 +: 8];
        d[48 +: 4] = r[8 +: 4];
        d[52 +: 4] = r[12 +: 4];
        d[40 +: 8] = r[16 +: 8];
        d[32 +: 8] = r[24 +: 8];
        d[24 +: 4] = r[32 +: 4];
        d[28 +: 4] = r[36 +: 4];
        d[16 +: 8] = r[40 +: 8];
        d[8 +: 8]  = r[48 +: 8];
        d[0 +: 4]  = r[56 +: 4];
        d[4 +: 4]  = r[60 +: 4];
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Frame-level reference: split fw into beats of W words, zero-pad the tail.
    task automatic model_push(input bit mode);
        int w, n, ng, idx;
        logic [767:0] bits;
        beat_t b;
        w  = mode ? 8 : WEXP;
        n  = fw.size();
        ng = (n + w - 1) / w;
        for (int g = 0; g < ng; g++) begin
            bits   = '0;
            b.data = '0;
            for (int k = 0; k < w; k++) begin
                idx = g * w + k;
                if (idx < n) bits[64*k +: 64] = mode ? fw[idx] : remap(fw[idx]);
            end
            if (mode) b.data = bits[511:0];
            else for (int i = 0; i < SPB; i++) b.data[OSB*i +: OSB] = {4'h0, bits[SB*i +: SB]};
            b.last = (g == ng - 1);
            if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(b);
        end
    endtask

    task automatic step();
        if (rand_ready) m_axis_tready = ($urandom_range(0, 9) < 7);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit m0, input bit mrest, input bit use_model);
        if (use_model) model_push(m0);
        for (int i = 0; i < fw.size(); i++) begin
            mode_i          = (i == 0) ? m0 : mrest;
            payload_i       = fw[i];
            payload_valid_i = 1'b1;
            payload_last_i  = (i == fw.size() - 1);
            step();
        end
        payload_valid_i = 1'b0;
        payload_last_i  = 1'b0;
    endtask

    task automatic rand_words(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back({$urandom, $urandom});
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            step();
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d beats pending expected=0", exp_q.size());
            exp_q.delete();
        end
        repeat (6) step();
    endtask

    // Scoreboard: every handshake must match the next expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_partial_o) err_seen++;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_t e;
                beats_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none", m_axis_tdata[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tkeep !== {64{1'b1}}) begin
                        failures++;
                        $display("FAIL beat_data actual=%0h/last%0b expected=%0h/last%0b",
                                 m_axis_tdata[127:0], m_axis_tlast, e.data[127:0], e.last);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        logic [767:0] s;
        beat_t       b;
        int          b0, e0, n, m, exp_err, occ;

        vecs[0] = '{1'b0, 6, 1, 0};
        vecs[1] = '{1'b1, 3, 1, 1};
        vecs[2] = '{1'b1, 16, 2, 0};
        vecs[3] = '{1'b0, 1, 1, 1};
        vecs[4] = '{1'b0, 7, 2, 1};
        vecs[5] = '{1'b0, 13, 3, 1};
        vecs[6] = '{1'b1, 9, 2, 1};
        vecs[7] = '{1'b0, 18, 3, 0};

        rst = 1'b1; mode_i = 1'b0; payload_i = 64'd0;
        payload_valid_i = 1'b0; payload_last_i = 1'b0; m_axis_tready = 1'b1;
        repeat (3) step();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_err", 64'(err_partial_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        chk("rst_space", 64'(space_avail_o), 64'd1);
        rst = 1'b0;
        step();

        // EXPAND, samples 0..63 ascending across 12 words.
        s = '0;
        for (int i = 0; i < 64; i++) s[SB*i +: SB] = 12'(i);
        fw.delete();
        for (int j = 0; j < 12; j++) fw.push_back(unremap(s[64*j +: 64]));
        for (int bb = 0; bb < 2; bb++) begin
            b.data = '0;
            for (int i = 0; i < SPB; i++) b.data[OSB*i +: OSB] = 16'(32 * bb + i);
            b.last = (bb == 1);
            exp_q.push_back(b);
        end
        b0 = beats_seen; e0 = err_seen;
        send_frame(1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("asc_beats", 64'(beats_seen - b0), 64'd2);
        chk("asc_err", 64'(err_seen - e0), 64'd0);

        // PASS, words 0..7, check two-cycle latency.
        fw.delete();
        for (int k = 0; k < 8; k++) fw.push_back(64'(k));
        b.data = '0;
        for (int k = 0; k < 8; k++) b.data[64*k +: 64] = 64'(k);
        b.last = 1'b1;
        exp_q.push_back(b);
        b0 = beats_seen;
        send_frame(1'b1, 1'b1, 1'b0);
        chk("lat_tvalid_c1", 64'(m_axis_tvalid), 64'd0);
        step();
        chk("lat_tvalid_c2", 64'(m_axis_tvalid), 64'd1);
        wait_drain();
        chk("pass_beats", 64'(beats_seen - b0), 64'd1);

        // Table of frame shapes.
        for (int v = 0; v < 8; v++) begin
            b0 = beats_seen; e0 = err_seen;
            rand_words(vecs[v].nwords);
            send_frame(vecs[v].mode, vecs[v].mode, 1'b1);
            wait_drain();
            chk($sformatf("vec%0d_beats", v), 64'(beats_seen - b0), 64'(vecs[v].exp_beats));
            chk($sformatf("vec%0d_err", v), 64'(err_seen - e0), 64'(vecs[v].exp_err));
        end

        // Early last on word 3, next frame starts in the write cycle.
        b0 = beats_seen; e0 = err_seen;
        rand_words(4);
        send_frame(1'b0, 1'b0, 1'b1);
        chk("early_err_pulse", 64'(err_partial_o), 64'd1);
        rand_words(6);
        send_frame(1'b0, 1'b0, 1'b1);
        wait_drain();
        chk("early_beats", 64'(beats_seen - b0), 64'd2);
        chk("early_err_count", 64'(err_seen - e0), 64'd1);

        // mode_i toggled mid-frame is ignored until the frame closes.
        b0 = beats_seen; e0 = err_seen;
        rand_words(6);
        send_frame(1'b0, 1'b1, 1'b1);
        rand_words(8);
        send_frame(1'b1, 1'b1, 1'b1);
        wait_drain();
        chk("toggle_beats", 64'(beats_seen - b0), 64'd2);
        chk("toggle_err", 64'(err_seen - e0), 64'd0);

        // Random frames with random backpressure.
        rand_ready = 1'b1;
        e0 = err_seen; exp_err = 0;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 20);
            m = $urandom_range(0, 1);
            if ((n % (m != 0 ? 8 : WEXP)) != 0) exp_err++;
            rand_words(n);
            send_frame(m[0], m[0], 1'b1);
            repeat ($urandom_range(0, 3)) step();
        end
        wait_drain();
        chk("rand_err", 64'(err_seen - e0), 64'(exp_err));
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;

        // Overflow: 65 beats with tready low.
        m_axis_tready = 1'b0;
        b0 = beats_seen;
        for (int f = 0; f < 65; f++) begin
            rand_words(8);
            send_frame(1'b1, 1'b1, 1'b1);
            repeat (3) step();
            occ = (f + 1 > DEPTH) ? DEPTH : f + 1;
            chk($sformatf("ovf_space%0d", f), 64'(space_avail_o), 64'((DEPTH - occ) >= CHUNK));
            chk($sformatf("ovf_flag%0d", f), 64'(ovf_o), 64'(f == 64));
        end
        chk("ovf_model", 64'(ovf_o), 64'(exp_ovf));
        m_axis_tready = 1'b1;
        wait_drain();
        chk("ovf_drained", 64'(beats_seen - b0), 64'd64);

        // Reset mid-frame, then a fresh frame.
        fw.delete();
        for (int i = 0; i < 3; i++) begin
            mode_i = 1'b0; payload_i = {$urandom, $urandom};
            payload_valid_i = 1'b1; payload_last_i = 1'b0;
            step();
        end
        payload_valid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_ovf", 64'(ovf_o), 64'd0);
        chk("rst2_space", 64'(space_avail_o), 64'd1);
        chk("rst2_tvalid", 64'(m_axis_tvalid), 64'd0);
        b0 = beats_seen; e0 = err_seen;
        rand_words(6);
        send_frame(1'b0, 1'b0, 1'b1);
        wait_drain();
        chk("rst2_beats", 64'(beats_seen - b0), 64'd1);
        chk("rst2_err", 64'(err_seen - e0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
